// File: rtl/alu_muldiv_if.sv
// Request/response bundle between the EX stage and the alu_muldiv HI/LO unit.
// The master modport is the pipeline side; the slave modport is the unit.
interface alu_muldiv_if #(
    parameter int NB_OP   = 6,
    parameter int NB_DATA = 32
);
    // Handshake: a request is accepted on a rising edge where i_valid & o_ready.
    // The requester holds i_valid (and i_op/i_data_*) while o_stall is high.
    // o_done is a one-cycle pulse when a MULT/DIV result lands in HI/LO.
    logic               i_valid;
    logic [NB_OP-1:0]   i_op;
    logic [NB_DATA-1:0] i_data_A;
    logic [NB_DATA-1:0] i_data_B;
    logic               o_ready;
    logic               o_done;
    logic               o_div_zero;
    logic [NB_DATA-1:0] o_hi;
    logic [NB_DATA-1:0] o_lo;
    logic [NB_DATA-1:0] o_data;
    logic               o_stall;
    logic [1:0]         dbg_state;

    modport master (
        output i_valid, i_op, i_data_A, i_data_B,
        input  o_ready, o_done, o_div_zero, o_hi, o_lo, o_data, o_stall, dbg_state
    );

    modport slave (
        input  i_valid, i_op, i_data_A, i_data_B,
        output o_ready, o_done, o_div_zero, o_hi, o_lo, o_data, o_stall, dbg_state
    );
endinterface

// File: rtl/alu_muldiv.sv
// Iterative MIPS multiply/divide unit with HI/LO registers.
// Define ALU_MULDIV_FAST_MULT_EN to compute MULT/MULTU with one combinational multiplier.
module alu_muldiv #(
    parameter int NB_OP   = 6,
    parameter int NB_DATA = 32,
    parameter int NB_CNT  = $clog2(NB_DATA + 1)
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    alu_muldiv_if.slave bus
);
    localparam logic [NB_OP-1:0] OP_MFHI  = NB_OP'(6'b010000);
    localparam logic [NB_OP-1:0] OP_MTHI  = NB_OP'(6'b010001);
    localparam logic [NB_OP-1:0] OP_MFLO  = NB_OP'(6'b010010);
    localparam logic [NB_OP-1:0] OP_MTLO  = NB_OP'(6'b010011);
    localparam logic [NB_OP-1:0] OP_MULT  = NB_OP'(6'b011000);
    localparam logic [NB_OP-1:0] OP_MULTU = NB_OP'(6'b011001);
    localparam logic [NB_OP-1:0] OP_DIV   = NB_OP'(6'b011010);
    localparam logic [NB_OP-1:0] OP_DIVU  = NB_OP'(6'b011011);

    typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2, FIX = 2'd3} state_e;

    state_e               state_q, state_d;
    logic [NB_CNT-1:0]    cnt_q, cnt_d;
    logic [2*NB_DATA-1:0] acc_q, acc_d;
    logic [NB_DATA-1:0]   opd_q, opd_d, a_raw_q, a_raw_d, hi_q, hi_d, lo_q, lo_d;
    logic                 is_div_q, is_div_d, neg_q, neg_d, neg_rem_q, neg_rem_d;
    logic                 dz_q, dz_d, ready_q, ready_d, done_q, done_d, dz_out_q, dz_out_d;

    logic op_mfhi, op_mflo, op_mthi, op_mtlo, op_mul, op_div, op_signed, op_known;
    logic accept, sign_a, sign_b;
    logic [NB_DATA-1:0]   mag_a, mag_b;
    logic [NB_DATA:0]     div_sh;
    logic [NB_DATA-1:0]   div_diff;
    logic                 div_ge;
    logic [2*NB_DATA-1:0] div_next, prod_fix;
    logic [NB_DATA-1:0]   quo_fix, rem_fix;

    assign op_mfhi   = (bus.i_op == OP_MFHI);
    assign op_mflo   = (bus.i_op == OP_MFLO);
    assign op_mthi   = (bus.i_op == OP_MTHI);
    assign op_mtlo   = (bus.i_op == OP_MTLO);
    assign op_mul    = (bus.i_op == OP_MULT) | (bus.i_op == OP_MULTU);
    assign op_div    = (bus.i_op == OP_DIV)  | (bus.i_op == OP_DIVU);
    assign op_signed = (bus.i_op == OP_MULT) | (bus.i_op == OP_DIV);
    assign op_known  = op_mfhi | op_mflo | op_mthi | op_mtlo | op_mul | op_div;
    assign accept    = bus.i_valid & ready_q;

    assign sign_a = op_signed & bus.i_data_A[NB_DATA-1];
    assign sign_b = op_signed & bus.i_data_B[NB_DATA-1];
    assign mag_a  = sign_a ? -bus.i_data_A : bus.i_data_A;
    assign mag_b  = sign_b ? -bus.i_data_B : bus.i_data_B;

    // Restoring divide: acc holds {remainder, quotient-in-progress}; opd is the divisor.
    assign div_sh   = {acc_q[2*NB_DATA-1:NB_DATA], acc_q[NB_DATA-1]};
    assign div_ge   = (div_sh >= {1'b0, opd_q});
    assign div_diff = div_sh[NB_DATA-1:0] - opd_q;
    assign div_next = div_ge ? {div_diff, acc_q[NB_DATA-2:0], 1'b1}
                             : {div_sh[NB_DATA-1:0], acc_q[NB_DATA-2:0], 1'b0};

`ifdef ALU_MULDIV_FAST_MULT_EN
    logic [2*NB_DATA-1:0] prod_fast;
    assign prod_fast = {{NB_DATA{1'b0}}, mag_a} * {{NB_DATA{1'b0}}, mag_b};
`else
    // Shift-add multiply: acc holds {partial product, remaining multiplier bits}.
    logic [NB_DATA-1:0]   mul_add;
    logic [NB_DATA:0]     mul_sum;
    logic [2*NB_DATA-1:0] mul_next;
    assign mul_add  = acc_q[0] ? opd_q : '0;
    assign mul_sum  = {1'b0, acc_q[2*NB_DATA-1:NB_DATA]} + {1'b0, mul_add};
    assign mul_next = {mul_sum, acc_q[NB_DATA-1:1]};
`endif

    assign prod_fix = neg_q ? -acc_q : acc_q;
    assign quo_fix  = neg_q ? -acc_q[NB_DATA-1:0] : acc_q[NB_DATA-1:0];
    assign rem_fix  = neg_rem_q ? -acc_q[2*NB_DATA-1:NB_DATA] : acc_q[2*NB_DATA-1:NB_DATA];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opd_d     = opd_q;
        a_raw_d   = a_raw_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        is_div_d  = is_div_q;
        neg_d     = neg_q;
        neg_rem_d = neg_rem_q;
        dz_d      = dz_q;
        ready_d   = ready_q;
        done_d    = 1'b0;
        dz_out_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (op_mthi) hi_d = bus.i_data_A;
                    if (op_mtlo) lo_d = bus.i_data_A;
                    if (op_mul | op_div) begin
                        a_raw_d   = bus.i_data_A;
                        is_div_d  = op_div;
                        neg_d     = sign_a ^ sign_b;
                        neg_rem_d = sign_a;
                        dz_d      = op_div & (bus.i_data_B == '0);
                        cnt_d     = NB_CNT'(NB_DATA);
                        ready_d   = 1'b0;
                        if (op_div) begin
                            state_d = DIV;
                            acc_d   = {{NB_DATA{1'b0}}, mag_a};
                            opd_d   = mag_b;
                        end else begin
`ifdef ALU_MULDIV_FAST_MULT_EN
                            state_d = FIX;
                            acc_d   = prod_fast;
`else
                            state_d = MUL;
                            acc_d   = {{NB_DATA{1'b0}}, mag_b};
                            opd_d   = mag_a;
`endif
                        end
                    end
                end
            end
`ifndef ALU_MULDIV_FAST_MULT_EN
            MUL: begin
                acc_d = mul_next;
                cnt_d = cnt_q - NB_CNT'(1);
                if (cnt_q == NB_CNT'(1)) state_d = FIX;
            end
`endif
            DIV: begin
                acc_d = div_next;
                cnt_d = cnt_q - NB_CNT'(1);
                if (cnt_q == NB_CNT'(1)) state_d = FIX;
            end
            FIX: begin
                if (is_div_q && dz_q) begin
                    // Divide by zero reports the dividend exactly as the requester gave it.
                    hi_d = a_raw_q;
                    lo_d = '1;
                end else if (is_div_q) begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end else begin
                    {hi_d, lo_d} = prod_fix;
                end
                done_d   = 1'b1;
                dz_out_d = is_div_q & dz_q;
                ready_d  = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            opd_q     <= '0;
            a_raw_q   <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
            dz_out_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opd_q     <= opd_d;
            a_raw_q   <= a_raw_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            is_div_q  <= is_div_d;
            neg_q     <= neg_d;
            neg_rem_q <= neg_rem_d;
            dz_q      <= dz_d;
            ready_q   <= ready_d;
            done_q    <= done_d;
            dz_out_q  <= dz_out_d;
        end
    end

    always_comb begin
        bus.o_data = '0;
        if (op_mfhi)      bus.o_data = hi_q;
        else if (op_mflo) bus.o_data = lo_q;
    end

    assign bus.o_ready    = ready_q;
    assign bus.o_done     = done_q;
    assign bus.o_div_zero = dz_out_q;
    assign bus.o_hi       = hi_q;
    assign bus.o_lo       = lo_q;
    assign bus.o_stall    = bus.i_valid & op_known & ~ready_q;
    assign bus.dbg_state  = state_q;
endmodule
